// File: rtl/nmi_arbiter_if.sv
// ============================================================================
// Module   : nmi_if
// Brief    : Native-IP request/response bundle shared by masters and slaves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nmi_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

`default_nettype wire

// File: rtl/nmi_arbiter.sv
// ============================================================================
// Module   : nmi_arbiter
// Brief    : Two-master round-robin arbiter onto one native-IP request port.
//            Optional watchdog selected by macro NMI_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nmi_arbiter #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    nmi_if.slave  m0,
    nmi_if.slave  m1,
    nmi_if.master s,
    output logic tmo_err_o
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_gnt0 = 2'd1;
    localparam logic [1:0]  c_st_gnt1 = 2'd2;
    localparam logic [31:0] c_tmo_rdata = 32'hDEAD_BEEF;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_lst;
    logic       w_lst_nxt;
    logic       w_tmo;

    if (TMO_CYC < 1 || TMO_CYC > 65535) begin : g_bad_tmo_cyc
        $error("nmi_arbiter: TMO_CYC out of range 1..65535");
    end

`ifdef NMI_ARB_TIMEOUT_EN
    localparam logic [15:0] c_tmo_cyc = 16'(TMO_CYC);
    logic [15:0] r_tmo_cnt;

    // Held at zero in IDLE so every grant starts counting from zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_state == c_st_idle) begin
            r_tmo_cnt <= 16'd0;
        end else if (!s.ready && !w_tmo) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_tmo = (r_state != c_st_idle) && (r_tmo_cnt == c_tmo_cyc);
`else
    assign w_tmo = 1'b0;
`endif

    assign tmo_err_o = w_tmo;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_st_idle;
            r_lst   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_lst   <= w_lst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lst_nxt   = r_lst;
        case (r_state)
            c_st_idle: begin
                if (m0.valid && m1.valid) begin
                    w_state_nxt = r_lst ? c_st_gnt0 : c_st_gnt1;
                end else if (m0.valid) begin
                    w_state_nxt = c_st_gnt0;
                end else if (m1.valid) begin
                    w_state_nxt = c_st_gnt1;
                end
            end
            c_st_gnt0: begin
                if (w_tmo || (m0.valid && s.ready)) begin
                    w_state_nxt = c_st_idle;
                    w_lst_nxt   = 1'b0;
                end else if (!m0.valid) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_gnt1: begin
                if (w_tmo || (m1.valid && s.ready)) begin
                    w_state_nxt = c_st_idle;
                    w_lst_nxt   = 1'b1;
                end else if (!m1.valid) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // A timed-out grant hides the request from the slave and answers the master locally.
    always_comb begin
        s.valid  = 1'b0;
        s.addr   = 32'h0;
        s.wdata  = 32'h0;
        s.wstrb  = 4'h0;
        m0.ready = 1'b0;
        m0.rdata = 32'h0;
        m1.ready = 1'b0;
        m1.rdata = 32'h0;
        case (r_state)
            c_st_gnt0: begin
                s.valid  = m0.valid && !w_tmo;
                s.addr   = m0.addr;
                s.wdata  = m0.wdata;
                s.wstrb  = m0.wstrb;
                m0.ready = w_tmo ? 1'b1 : s.ready;
                m0.rdata = w_tmo ? c_tmo_rdata : s.rdata;
            end
            c_st_gnt1: begin
                s.valid  = m1.valid && !w_tmo;
                s.addr   = m1.addr;
                s.wdata  = m1.wdata;
                s.wstrb  = m1.wstrb;
                m1.ready = w_tmo ? 1'b1 : s.ready;
                m1.rdata = w_tmo ? c_tmo_rdata : s.rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_nmi_arbiter.sv
// ============================================================================
// Module   : tb_nmi_arbiter
// Brief    : Self-checking bench for nmi_arbiter (vectors, corner sequences,
//            random traffic against a transaction-level model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nmi_arbiter;

    localparam int c_tmo = 8;
`ifdef NMI_ARB_TIMEOUT_EN
    localparam bit c_tmo_en = 1'b1;
`else
    localparam bit c_tmo_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n_i = 1'b0;
    logic tmo_err_o;

    nmi_if m0_if ();
    nmi_if m1_if ();
    nmi_if s_if ();

    nmi_arbiter #(.TMO_CYC(c_tmo)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n_i),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .tmo_err_o (tmo_err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_if.valid = 1'b0; m0_if.addr = 32'h0; m0_if.wdata = 32'h0; m0_if.wstrb = 4'h0;
        m1_if.valid = 1'b0; m1_if.addr = 32'h0; m1_if.wdata = 32'h0; m1_if.wstrb = 4'h0;
        s_if.ready  = 1'b0; s_if.rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n_i = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n_i = 1'b1;
    endtask

    typedef struct {
        bit          rst_n, v0, v1, sr;
        logic [31:0] rd;
        bit          e_sv;
        logic [31:0] e_saddr;
        bit          e_r0;
        logic [31:0] e_rd0;
        bit          e_r1;
        logic [31:0] e_rd1;
    } vec_t;

    vec_t tbl[15];

    // Transaction-level reference: who owns the slave, who went last, how long it waited.
    int mdl_owner;
    bit mdl_lst;
    int mdl_wait;

    initial begin
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;

        // Single read, then contested round-robin (reset restores m0 priority).
        tbl[0]  = '{1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0};
        tbl[1]  = '{1, 1, 0, 0, 32'h0,         1, 32'h1000_0000, 0, 32'h0,         0, 32'h0};
        tbl[2]  = '{1, 1, 0, 0, 32'h0,         1, 32'h1000_0000, 0, 32'h0,         0, 32'h0};
        tbl[3]  = '{1, 1, 0, 1, 32'hA5A5_0001, 1, 32'h1000_0000, 1, 32'hA5A5_0001, 0, 32'h0};
        tbl[4]  = '{1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0};
        tbl[5]  = '{0, 1, 1, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0};
        tbl[6]  = '{1, 1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0};
        tbl[7]  = '{1, 1, 1, 1, 32'h11,        1, 32'h1000_0000, 1, 32'h11,        0, 32'h0};
        tbl[8]  = '{1, 0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0};
        tbl[9]  = '{1, 0, 1, 1, 32'h22,        1, 32'h2000_0000, 0, 32'h0,         1, 32'h22};
        tbl[10] = '{1, 1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0};
        tbl[11] = '{1, 1, 1, 1, 32'h33,        1, 32'h1000_0000, 1, 32'h33,        0, 32'h0};
        tbl[12] = '{1, 1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0};
        tbl[13] = '{1, 1, 1, 1, 32'h44,        1, 32'h2000_0000, 0, 32'h0,         1, 32'h44};
        tbl[14] = '{1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0};

        m0_if.addr = 32'h1000_0000;
        m1_if.addr = 32'h2000_0000;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst_n_i     = tbl[i].rst_n;
            m0_if.valid = tbl[i].v0;
            m1_if.valid = tbl[i].v1;
            s_if.ready  = tbl[i].sr;
            s_if.rdata  = tbl[i].rd;
            #1;
            chk($sformatf("vec%0d s.valid", i),  32'(s_if.valid),  32'(tbl[i].e_sv));
            chk($sformatf("vec%0d s.addr", i),   s_if.addr,        tbl[i].e_saddr);
            chk($sformatf("vec%0d m0.ready", i), 32'(m0_if.ready), 32'(tbl[i].e_r0));
            chk($sformatf("vec%0d m0.rdata", i), m0_if.rdata,      tbl[i].e_rd0);
            chk($sformatf("vec%0d m1.ready", i), 32'(m1_if.ready), 32'(tbl[i].e_r1));
            chk($sformatf("vec%0d m1.rdata", i), m1_if.rdata,      tbl[i].e_rd1);
        end

        // m1 write holds the slave while m0 arrives mid-transfer.
        do_reset();
        @(negedge clk);
        m1_if.valid = 1'b1; m1_if.addr = 32'h2000_0010;
        m1_if.wdata = 32'h1234_5678; m1_if.wstrb = 4'hF;
        #1 chk("wr idle s.valid", 32'(s_if.valid), 32'h0);
        @(negedge clk);
        m0_if.valid = 1'b1; m0_if.addr = 32'h1000_0020;
        m0_if.wdata = 32'h8765_4321; m0_if.wstrb = 4'h3;
        #1;
        chk("wr s.valid", 32'(s_if.valid), 32'h1);
        chk("wr s.addr", s_if.addr, 32'h2000_0010);
        chk("wr s.wstrb", 32'(s_if.wstrb), 32'hF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk($sformatf("wr hold%0d s.wdata", k), s_if.wdata, 32'h1234_5678);
            chk($sformatf("wr hold%0d m0.ready", k), 32'(m0_if.ready), 32'h0);
        end
        @(negedge clk);
        s_if.ready = 1'b1; s_if.rdata = 32'hCAFE_0001;
        #1;
        chk("wr m1.ready", 32'(m1_if.ready), 32'h1);
        chk("wr m0.rdata", m0_if.rdata, 32'h0);
        @(negedge clk);
        m1_if.valid = 1'b0; s_if.ready = 1'b0;
        #1 chk("wr gap s.valid", 32'(s_if.valid), 32'h0);
        @(negedge clk); #1;
        chk("wr m0 next s.addr", s_if.addr, 32'h1000_0020);
        chk("wr m0 next s.wdata", s_if.wdata, 32'h8765_4321);

        // Asynchronous reset during an m1 wait state.
        do_reset();
        @(negedge clk);
        m1_if.valid = 1'b1; m1_if.addr = 32'h2000_0030;
        @(negedge clk);
        #1 chk("rst gnt1 s.valid", 32'(s_if.valid), 32'h1);
        @(negedge clk);
        s_if.ready = 1'b1;
        #1 chk("rst pre m1.ready", 32'(m1_if.ready), 32'h1);
        #1 rst_n_i = 1'b0;
        #1;
        chk("rst async s.valid", 32'(s_if.valid), 32'h0);
        chk("rst async m1.ready", 32'(m1_if.ready), 32'h0);
        @(negedge clk);
        rst_n_i = 1'b1; s_if.ready = 1'b0;
        m0_if.valid = 1'b1; m0_if.addr = 32'h1000_0040;
        #1 chk("rst post idle s.valid", 32'(s_if.valid), 32'h0);
        @(negedge clk); #1;
        chk("rst post grant s.addr", s_if.addr, 32'h1000_0040);
        chk("rst post m1.ready", 32'(m1_if.ready), 32'h0);

        // Watchdog behaviour with the slave never answering.
        do_reset();
        @(negedge clk);
        m0_if.valid = 1'b1; m0_if.addr = 32'h1000_0050;
        if (c_tmo_en) begin
            for (int k = 0; k <= c_tmo; k++) begin
                @(negedge clk); #1;
                if (k < c_tmo) begin
                    chk($sformatf("tmo wait%0d m0.ready", k), 32'(m0_if.ready), 32'h0);
                    chk($sformatf("tmo wait%0d tmo_err", k), 32'(tmo_err_o), 32'h0);
                end else begin
                    chk("tmo m0.ready", 32'(m0_if.ready), 32'h1);
                    chk("tmo m0.rdata", m0_if.rdata, 32'hDEAD_BEEF);
                    chk("tmo tmo_err", 32'(tmo_err_o), 32'h1);
                    chk("tmo s.valid", 32'(s_if.valid), 32'h0);
                end
            end
            @(negedge clk); #1;
            chk("tmo pulse end", 32'(tmo_err_o), 32'h0);
        end else begin
            bit seen_ready = 1'b0;
            bit seen_err   = 1'b0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk); #1;
                if (m0_if.ready) seen_ready = 1'b1;
                if (tmo_err_o)   seen_err   = 1'b1;
            end
            chk("no-tmo m0.ready seen", 32'(seen_ready), 32'h0);
            chk("no-tmo tmo_err seen", 32'(seen_err), 32'h0);
            chk("no-tmo s.valid held", 32'(s_if.valid), 32'h1);
        end

        // Random traffic against the reference model.
        do_reset();
        mdl_owner = -1; mdl_lst = 1'b1; mdl_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            bit          v[2];
            bit          tmo;
            bit          e_sv, e_tmo;
            bit          e_r[2];
            logic [31:0] e_rd[2];
            logic [31:0] e_addr, e_wdata;
            logic [3:0]  e_wstrb;

            @(negedge clk);
            rst_n_i     = ($urandom_range(0, 99) != 0);
            m0_if.valid = (mdl_owner == 0) ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
            m1_if.valid = (mdl_owner == 1) ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
            m0_if.addr  = $urandom; m0_if.wdata = $urandom; m0_if.wstrb = 4'($urandom);
            m1_if.addr  = $urandom; m1_if.wdata = $urandom; m1_if.wstrb = 4'($urandom);
            s_if.ready  = ($urandom_range(0, 5) == 0);
            s_if.rdata  = $urandom;
            #1;

            if (!rst_n_i) begin
                mdl_owner = -1; mdl_lst = 1'b1; mdl_wait = 0;
            end
            v[0] = m0_if.valid;
            v[1] = m1_if.valid;
            tmo  = c_tmo_en && (mdl_owner >= 0) && (mdl_wait == c_tmo);

            e_sv = 1'b0; e_tmo = tmo; e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
            e_r[0] = 1'b0; e_r[1] = 1'b0; e_rd[0] = 32'h0; e_rd[1] = 32'h0;
            if (mdl_owner == 0) begin
                e_sv = v[0] && !tmo; e_addr = m0_if.addr; e_wdata = m0_if.wdata; e_wstrb = m0_if.wstrb;
            end else if (mdl_owner == 1) begin
                e_sv = v[1] && !tmo; e_addr = m1_if.addr; e_wdata = m1_if.wdata; e_wstrb = m1_if.wstrb;
            end
            if (mdl_owner >= 0) begin
                e_r[mdl_owner]  = tmo ? 1'b1 : s_if.ready;
                e_rd[mdl_owner] = tmo ? 32'hDEAD_BEEF : s_if.rdata;
            end

            chk($sformatf("rnd%0d s.valid", c),  32'(s_if.valid),  32'(e_sv));
            chk($sformatf("rnd%0d s.addr", c),   s_if.addr,        e_addr);
            chk($sformatf("rnd%0d s.wdata", c),  s_if.wdata,       e_wdata);
            chk($sformatf("rnd%0d s.wstrb", c),  32'(s_if.wstrb),  32'(e_wstrb));
            chk($sformatf("rnd%0d m0.ready", c), 32'(m0_if.ready), 32'(e_r[0]));
            chk($sformatf("rnd%0d m0.rdata", c), m0_if.rdata,      e_rd[0]);
            chk($sformatf("rnd%0d m1.ready", c), 32'(m1_if.ready), 32'(e_r[1]));
            chk($sformatf("rnd%0d m1.rdata", c), m1_if.rdata,      e_rd[1]);
            chk($sformatf("rnd%0d tmo_err", c),  32'(tmo_err_o),   32'(e_tmo));

            if (!rst_n_i) begin
                // reset held over the edge: nothing advances
            end else if (mdl_owner < 0) begin
                mdl_wait = 0;
                if (v[0] && v[1]) mdl_owner = mdl_lst ? 0 : 1;
                else if (v[0])    mdl_owner = 0;
                else if (v[1])    mdl_owner = 1;
            end else if (tmo || (v[mdl_owner] && s_if.ready)) begin
                mdl_lst   = 1'(mdl_owner);
                mdl_owner = -1;
            end else if (!v[mdl_owner]) begin
                mdl_owner = -1;
            end else begin
                mdl_wait++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nmi_arbiter.md
NMI_ARBITER -- requirements
Module: nmi_arbiter

Interface
REQ-001 SHALL provide parameter: TMO_CYC, default 255, number of cycles a granted transfer may wait for s.ready before forced completion (1..65535).
REQ-002 SHALL provide port: clk_i  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL provide port: rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: m0  nmi_if.slave  bundle  CPU-side request (valid/addr[31:0]/wdata[31:0]/wstrb[3:0] in; ready/rdata[31:0] out).
REQ-005 SHALL provide port: m1  nmi_if.slave  bundle  DMA-side request, same fields as m0.
REQ-006 SHALL provide port: s  nmi_if.master  bundle  merged request toward the native-IP decode/wrapper.
REQ-007 SHALL provide port: tmo_err_o  output  1  one-cycle pulse on forced timeout completion.

Function
REQ-008 SHALL implement FSM states IDLE, GNT0, GNT1 plus a 1-bit last-served pointer lst.
REQ-009 In IDLE, s.valid SHALL be 0 and m0.ready/m1.ready SHALL be 0.
REQ-010 In IDLE with exactly one of m0.valid/m1.valid high, next state SHALL be the GNT state of that master.
REQ-011 In IDLE with both valid, next state SHALL be GNT0 if lst==1, else GNT1 (round-robin).
REQ-012 In GNTn, s.valid/addr/wdata/wstrb SHALL equal mn's fields combinationally; mn.ready SHALL equal s.ready; mn.rdata SHALL equal s.rdata.
REQ-013 In GNTn, the non-granted master's ready SHALL be 0 and its rdata 32'h0.
REQ-014 In IDLE, s.addr/wdata/wstrb SHALL be driven 0.
REQ-015 Arbitration latency SHALL be exactly one cycle: request visible on s the cycle after valid is first sampled in IDLE.
REQ-016 On s.valid && s.ready in GNTn, the FSM SHALL return to IDLE next cycle and set lst=n.
REQ-017 If mn.valid drops in GNTn without s.ready (protocol violation), the FSM SHALL return to IDLE; lst unchanged.
REQ-018 A master whose valid is held through IDLE after completion SHALL be re-arbitrated normally; no back-to-back grant without passing IDLE.
REQ-019 New requests arriving while in GNTn SHALL wait; they SHALL NOT alter the current grant.

Reset
REQ-020 On rst_n_i low, state SHALL become IDLE, lst=1 (m0 favoured first), timeout counter 0, tmo_err_o 0, all readys 0, s.valid 0, asynchronously and mid-transfer.
REQ-021 Deassertion SHALL take effect on the next clk_i edge; no transfer in flight at reset SHALL be completed afterwards.

Configuration
REQ-022 Macro NMI_ARB_TIMEOUT_EN SHALL select the timeout watchdog.
REQ-023 With NMI_ARB_TIMEOUT_EN defined: 16-bit counter clears on GNT entry, increments each GNTn cycle with s.ready==0; when it equals TMO_CYC, that cycle s.valid SHALL be 0, mn.ready 1, mn.rdata 32'hDEAD_BEEF, tmo_err_o 1, next state IDLE, lst=n.
REQ-024 Without NMI_ARB_TIMEOUT_EN: no counter is synthesized, GNTn waits indefinitely, tmo_err_o SHALL be tied 0.
REQ-025 s.ready arriving in the same cycle the counter reaches TMO_CYC SHALL not occur as a conflict: timeout has priority, s.valid is already 0 so s.ready is ignored.

Verification
REQ-026 Single m0 read addr 32'h1000_0000, slave ready after 3 cycles with rdata 32'hA5A5_0001 -> m0.ready one pulse, m0.rdata 32'hA5A5_0001, s.valid visible 1 cycle after m0.valid.
REQ-027 m0 and m1 valid same cycle after reset -> m0 served first, then m1; repeat both again -> m0 then m1 alternate (lst toggles).
REQ-028 m1 write wdata 32'h1234_5678 wstrb 4'hF while m0 arrives mid-transfer -> s fields stay m1's until ready, m0 granted after IDLE cycle.
REQ-029 NMI_ARB_TIMEOUT_EN, TMO_CYC=8, slave never ready -> after 8 cycles in GNT0, m0.ready=1, rdata 32'hDEAD_BEEF, tmo_err_o one-cycle pulse; without macro, m0.ready stays 0 for 1000 cycles.
REQ-030 rst_n_i asserted during GNT1 wait -> s.valid and m1.ready 0 immediately (same cycle, asynchronous), state IDLE, first post-reset contested grant goes to m0.
